// File: rtl/io_tx_responder.sv
// Memory-side responder for the TX channel FIFO: walks an address range,
// issues L2 reads with a bounded number in flight and returns the data.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for a start pulse
// ST_RUN   | granting channel requests as L2 reads
// ST_DRAIN | all bytes issued, waiting for the remaining reads to return
// ST_ABORT | cleared, dropping returning reads until none are in flight
module io_tx_responder #(
  parameter int L2_AWIDTH       = 19,
  parameter int TRANS_SIZE      = 16,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  clr_i,
  input  logic                  cfg_start_i,
  input  logic [L2_AWIDTH-1:0]  cfg_addr_i,
  input  logic [TRANS_SIZE-1:0] cfg_size_i,
  input  logic [1:0]            cfg_datasize_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [L2_AWIDTH-1:0]  cur_addr_o,
  output logic [TRANS_SIZE-1:0] bytes_left_o,
  input  logic                  req_i,
  output logic                  gnt_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  mem_req_o,
  output logic [L2_AWIDTH-1:0]  mem_addr_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ABORT = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [L2_AWIDTH-1:0]  addr_q, addr_d;
  logic [TRANS_SIZE-1:0] left_q, left_d;
  logic [2:0]            incr_q, incr_d;
  logic [OW-1:0]         outst_q, outst_d;
  logic                  done_q, done_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic                  can_issue;
  logic                  mem_req;
  logic                  grant;
  logic [TRANS_SIZE-1:0] incr_ext;
  logic [TRANS_SIZE-1:0] left_after;

  function automatic logic [2:0] unit_bytes(input logic [1:0] ds);
    case (ds)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    left_d  = left_q;
    incr_d  = incr_q;
    outst_d = outst_q;
    done_d  = 1'b0;

    can_issue  = (outst_q < MAX_OUT);
    mem_req    = (state_q == ST_RUN) && req_i && can_issue;
    grant      = mem_req && mem_gnt_i;
    incr_ext   = TRANS_SIZE'(incr_q);
    // A trailing partial unit still costs a full read; the count saturates.
    left_after = (left_q <= incr_ext) ? '0 : left_q - incr_ext;

    valid_d = mem_rvalid_i && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
    data_d  = valid_d ? mem_rdata_i : data_q;

    if (grant && !mem_rvalid_i) begin
      outst_d = outst_q + 1'b1;
    end else if (!grant && mem_rvalid_i) begin
      outst_d = outst_q - 1'b1;
    end

    if (grant) begin
      addr_d = addr_q + L2_AWIDTH'(incr_q);
      left_d = left_after;
    end

    case (state_q)
      ST_IDLE: begin
        if (cfg_start_i && !clr_i) begin
          if (cfg_size_i != '0) begin
            addr_d  = cfg_addr_i;
            left_d  = cfg_size_i;
            incr_d  = unit_bytes(cfg_datasize_i);
            state_d = ST_RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (clr_i) begin
          state_d = ST_ABORT;
          left_d  = '0;
        end else if (grant && (left_after == '0)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (clr_i) begin
          state_d = ST_ABORT;
          left_d  = '0;
        end else if ((outst_q == '0) && !mem_rvalid_i) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      ST_ABORT: begin
        if (outst_q == '0) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      left_q  <= '0;
      incr_q  <= '0;
      outst_q <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      left_q  <= left_d;
      incr_q  <= incr_d;
      outst_q <= outst_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = done_q;
  assign cur_addr_o   = addr_q;
  assign bytes_left_o = left_q;
  assign mem_req_o    = mem_req;
  assign mem_addr_o   = addr_q;
  assign gnt_o        = grant;
  assign valid_o      = valid_q;
  assign data_o       = data_q;

endmodule

// File: tb/tb_io_tx_responder.sv
// Bench for io_tx_responder: transaction-level reference model checked every
// cycle, an L2 responder with configurable latency, directed and random runs.
module tb_io_tx_responder;
  localparam int AW = 19;
  localparam int SW = 16;
  localparam int DW = 32;
  localparam int MO = 4;

  logic          clk_i = 1'b0;
  logic          rstn_i = 1'b1;
  logic          clr_i = 1'b0;
  logic          cfg_start_i = 1'b0;
  logic [AW-1:0] cfg_addr_i = '0;
  logic [SW-1:0] cfg_size_i = '0;
  logic [1:0]    cfg_datasize_i = '0;
  logic          req_i = 1'b0;
  logic          mem_gnt_i = 1'b0;
  logic          mem_rvalid_i = 1'b0;
  logic [DW-1:0] mem_rdata_i = '0;
  logic          busy_o, done_o, gnt_o, valid_o, mem_req_o;
  logic [AW-1:0] cur_addr_o, mem_addr_o;
  logic [SW-1:0] bytes_left_o;
  logic [DW-1:0] data_o;

  io_tx_responder #(
    .L2_AWIDTH(AW), .TRANS_SIZE(SW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .clr_i(clr_i), .cfg_start_i(cfg_start_i),
    .cfg_addr_i(cfg_addr_i), .cfg_size_i(cfg_size_i), .cfg_datasize_i(cfg_datasize_i),
    .busy_o(busy_o), .done_o(done_o), .cur_addr_o(cur_addr_o), .bytes_left_o(bytes_left_o),
    .req_i(req_i), .gnt_o(gnt_o), .data_o(data_o), .valid_o(valid_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  int unsigned cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mdata(input logic [AW-1:0] a);
    return 32'hC0DE_0000 ^ ({13'd0, a} * 32'd40503);
  endfunction

  // L2 responder: in-order returns, latency drawn from [lat_min, lat_max]
  typedef struct { int unsigned due; logic [31:0] data; } rsp_t;
  rsp_t        rsp_q[$];
  int          lat_min = 1;
  int          lat_max = 1;
  int unsigned last_due = 0;

  // reference model: phase 0 idle, 1 issuing, 2 draining, 3 aborting
  int            m_phase;
  logic [AW-1:0] m_addr;
  logic [SW-1:0] m_left;
  int            m_incr;
  int            m_outst;
  bit            m_valid, m_done;
  logic [DW-1:0] m_data;
  logic [AW-1:0] m_aq[$];

  // observation logs for the directed checks
  logic [AW-1:0] glog[$];
  logic [SW-1:0] gleft[$];
  int unsigned   vcyc[$];
  logic [DW-1:0] vdata[$];
  int unsigned   dcyc[$];
  logic          dbusy[$];
  int            out_cnt = 0;
  int            peak = 0;

  bit            e_req, e_gnt, nv, ndone;
  logic [DW-1:0] nd;
  logic [AW-1:0] pa;
  int            old_outst;
  int unsigned   due;

  always @(negedge clk_i) begin
    if (!rstn_i) begin
      m_phase = 0; m_addr = '0; m_left = '0; m_incr = 1; m_outst = 0;
      m_valid = 0; m_done = 0; m_data = '0;
      m_aq.delete(); rsp_q.delete();
    end
    e_req = (m_phase == 1) && req_i && (m_outst < MO);
    e_gnt = e_req && mem_gnt_i;
    chk("busy_o", busy_o, m_phase != 0);
    chk("done_o", done_o, m_done);
    chk("mem_req_o", mem_req_o, e_req);
    chk("gnt_o", gnt_o, e_gnt);
    if (e_req) chk("mem_addr_o", mem_addr_o, m_addr);
    chk("cur_addr_o", cur_addr_o, m_addr);
    chk("bytes_left_o", bytes_left_o, m_left);
    chk("valid_o", valid_o, m_valid);
    chk("data_o", data_o, m_data);

    if (rstn_i) begin
      if (gnt_o) begin glog.push_back(mem_addr_o); gleft.push_back(bytes_left_o); end
      if (valid_o) begin vcyc.push_back(cyc); vdata.push_back(data_o); end
      if (done_o) begin dcyc.push_back(cyc); dbusy.push_back(busy_o); end
      out_cnt = out_cnt + int'(gnt_o) - int'(mem_rvalid_i);
      if (out_cnt > peak) peak = out_cnt;

      if (mem_req_o && mem_gnt_i) begin
        due = cyc + $urandom_range(lat_max, lat_min);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        rsp_q.push_back('{due, mdata(mem_addr_o)});
      end

      old_outst = m_outst;
      nv = 0; nd = m_data; ndone = 0;
      if (mem_rvalid_i) begin
        if (m_aq.size() == 0) begin
          chk("rvalid_without_read", 1'b1, 1'b0);
        end else begin
          pa = m_aq.pop_front();
          if (m_phase == 1 || m_phase == 2) begin nv = 1; nd = mdata(pa); end
        end
      end
      if (e_gnt) begin
        m_aq.push_back(m_addr);
        m_addr = m_addr + AW'(m_incr);
        m_left = (m_left <= m_incr) ? '0 : m_left - SW'(m_incr);
      end
      m_outst = m_outst + int'(e_gnt) - int'(mem_rvalid_i);
      case (m_phase)
        0: if (cfg_start_i && !clr_i) begin
             if (cfg_size_i != 0) begin
               m_addr = cfg_addr_i; m_left = cfg_size_i;
               m_incr = (cfg_datasize_i == 0) ? 1 : (cfg_datasize_i == 1) ? 2 : 4;
               m_phase = 1;
             end else ndone = 1;
           end
        1: if (clr_i) begin m_phase = 3; m_left = '0; end
           else if (e_gnt && m_left == 0) m_phase = 2;
        2: if (clr_i) begin m_phase = 3; m_left = '0; end
           else if (old_outst == 0) begin m_phase = 0; ndone = 1; end
        default: if (old_outst == 0) m_phase = 0;
      endcase
      m_valid = nv; m_data = nd; m_done = ndone;
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
    if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = rsp_q[0].data;
      void'(rsp_q.pop_front());
    end else begin
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = $urandom;
    end
  endtask

  task automatic clear_logs();
    glog.delete(); gleft.delete(); vcyc.delete(); vdata.delete();
    dcyc.delete(); dbusy.delete(); peak = 0;
  endtask

  int unsigned st_cyc;
  task automatic start_xfer(input logic [AW-1:0] a, input logic [SW-1:0] s, input logic [1:0] d);
    cfg_addr_i = a; cfg_size_i = s; cfg_datasize_i = d; cfg_start_i = 1'b1;
    st_cyc = cyc;
    step();
    cfg_start_i = 1'b0;
  endtask

  int reqp = 100;
  int gntp = 100;
  task automatic run_until_idle(input int maxc, input bit rnd);
    int n = 0;
    do begin
      if (rnd) begin
        req_i       = ($urandom_range(99) < reqp);
        mem_gnt_i   = ($urandom_range(99) < gntp);
        clr_i       = ($urandom_range(149) == 0);
        cfg_start_i = busy_o && ($urandom_range(29) == 0);
        cfg_addr_i  = $urandom; cfg_size_i = $urandom; cfg_datasize_i = $urandom;
      end
      step();
      n++;
    end while ((busy_o || m_phase != 0 || rsp_q.size() != 0) && n < maxc);
    if (rnd) begin clr_i = 1'b0; cfg_start_i = 1'b0; end
    if (n >= maxc) begin
      n_tests++; n_fail++;
      $display("FAIL idle_timeout: still busy after %0d cycles, required idle", n);
    end
    repeat (2) step();
  endtask

  initial begin
    #2 rstn_i = 1'b0;
    repeat (3) step();
    rstn_i = 1'b1;
    step();

    // basic word transfer
    clear_logs(); lat_min = 1; lat_max = 1; req_i = 1; mem_gnt_i = 1;
    start_xfer(19'h100, 16'd16, 2'b10);
    run_until_idle(200, 0);
    chk("basic_grants", glog.size(), 4);
    for (int i = 0; i < 4 && i < glog.size(); i++) chk("basic_addr", glog[i], 19'h100 + 4 * i);
    chk("basic_valids", vcyc.size(), 4);
    for (int i = 0; i < 4 && i < vdata.size(); i++) chk("basic_data", vdata[i], mdata(AW'(19'h100 + 4 * i)));
    chk("basic_dones", dcyc.size(), 1);
    if (dcyc.size() == 1 && vcyc.size() == 4) chk("basic_done_cycle", dcyc[0], vcyc[3] + 1);
    if (dbusy.size() == 1) chk("basic_busy_at_done", dbusy[0], 1'b0);

    // outstanding limit
    clear_logs(); lat_min = 10; lat_max = 10;
    start_xfer(19'h2000, 16'd32, 2'b10);
    run_until_idle(400, 0);
    chk("limit_peak", peak, 4);
    chk("limit_grants", glog.size(), 8);
    chk("limit_valids", vcyc.size(), 8);

    // byte unit with address wrap
    clear_logs(); lat_min = 1; lat_max = 3;
    start_xfer(19'h7FFFE, 16'd3, 2'b00);
    run_until_idle(200, 0);
    chk("wrap_grants", glog.size(), 3);
    if (glog.size() == 3) begin
      chk("wrap_addr0", glog[0], 19'h7FFFE);
      chk("wrap_addr1", glog[1], 19'h7FFFF);
      chk("wrap_addr2", glog[2], 19'h00000);
    end

    // odd size
    clear_logs(); lat_min = 1; lat_max = 1;
    start_xfer(19'h40, 16'd6, 2'b11);
    run_until_idle(200, 0);
    chk("odd_grants", glog.size(), 2);
    if (gleft.size() == 2) begin
      chk("odd_left0", gleft[0], 6);
      chk("odd_left1", gleft[1], 2);
    end
    chk("odd_left_end", bytes_left_o, 0);

    // abort with two reads in flight
    clear_logs(); lat_min = 5; lat_max = 5; req_i = 0;
    start_xfer(19'h200, 16'd16, 2'b10);
    req_i = 1; step(); step();
    req_i = 0; clr_i = 1; step();
    clr_i = 0;
    run_until_idle(200, 0);
    chk("abort_grants", glog.size(), 2);
    chk("abort_valids", vcyc.size(), 0);
    chk("abort_dones", dcyc.size(), 0);
    clear_logs(); req_i = 1; lat_min = 1; lat_max = 2;
    start_xfer(19'h300, 16'd8, 2'b10);
    run_until_idle(200, 0);
    chk("post_abort_valids", vcyc.size(), 2);
    chk("post_abort_dones", dcyc.size(), 1);

    // start while busy is ignored
    clear_logs(); lat_min = 3; lat_max = 3;
    start_xfer(19'h400, 16'd12, 2'b10);
    start_xfer(19'h500, 16'd4, 2'b00);
    run_until_idle(200, 0);
    chk("busy_start_grants", glog.size(), 3);
    if (glog.size() == 3) chk("busy_start_last_addr", glog[2], 19'h408);

    // zero-size start
    clear_logs();
    start_xfer(19'h600, 16'd0, 2'b10);
    repeat (3) step();
    chk("zero_grants", glog.size(), 0);
    chk("zero_dones", dcyc.size(), 1);
    if (dcyc.size() == 1) chk("zero_done_cycle", dcyc[0], st_cyc + 1);

    // clear wins over a same-cycle start in idle
    clear_logs(); clr_i = 1;
    start_xfer(19'h700, 16'd8, 2'b10);
    clr_i = 0;
    repeat (3) step();
    chk("clr_start_grants", glog.size(), 0);
    chk("clr_start_busy", busy_o, 1'b0);

    // randomized transfers
    for (int t = 0; t < 60; t++) begin
      reqp = $urandom_range(100, 30); gntp = $urandom_range(100, 30);
      lat_min = $urandom_range(4, 1); lat_max = lat_min + $urandom_range(6);
      start_xfer(AW'($urandom), SW'($urandom_range(40)), 2'($urandom));
      run_until_idle(3000, 1);
    end
    req_i = 0; mem_gnt_i = 0;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
